lotr_eot_ctrl: RTL and testbench

//  Synthesizable end-of-test controller for an N-tile LOTR fabric.

---
 rtl/lotr_pkg.sv | 32 +++
 rtl/lotr_eot_walker.sv | 115 +++++++++++
 rtl/lotr_eot_ctrl.sv | 112 +++++++++++
 tb/tb_lotr_eot_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// lotr_pkg: shared state/status types and width helper for the LOTR end-of-test controller.
// No ports; imported by lotr_eot_walker and lotr_eot_ctrl.
`ifndef LOTR_MSFF_RST
`define LOTR_MSFF_RST(q, d, rv, clk, rst) \
  always_ff @(posedge clk or posedge rst) \
    if (rst) q <= rv; \
    else q <= d;
`endif

package lotr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RD_REQ,
    RD_WAIT,
    OUT,
    DONE
  } eot_state_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_TIMEOUT = 2'b10
  } eot_status_t;

  // $clog2 with a floor of one bit, so single-entry indices stay legal.
  function automatic int eot_tile_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lotr_eot_walker.sv
// lotr_eot_walker: walks DUMP_WORDS words of every tile over a d_mem read port.
// Ports: clk/rst, start pulse, rd_* request/grant/data, dump_* valid/ready beat, done.
`ifndef LOTR_MSFF_RST
`define LOTR_MSFF_RST(q, d, rv, clk, rst) \
  always_ff @(posedge clk or posedge rst) \
    if (rst) q <= rv; \
    else q <= d;
`endif

module lotr_eot_walker
  import lotr_pkg::*;
#(
  parameter int                NUM_TILE   = 2,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DUMP_BASE  = '0,
  parameter int                DUMP_WORDS = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             rd_req,
  output logic [eot_tile_w(NUM_TILE)-1:0]  rd_tile,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic                             rd_gnt,
  input  logic                             rd_vld,
  input  logic [DATA_W-1:0]                rd_data,
  output logic                             dump_vld,
  input  logic                             dump_rdy,
  output logic [eot_tile_w(NUM_TILE)-1:0]  dump_tile,
  output logic [ADDR_W-1:0]                dump_addr,
  output logic [DATA_W-1:0]                dump_data,
  output logic                             done
);

  localparam int TW = eot_tile_w(NUM_TILE);
  localparam int WW = eot_tile_w(DUMP_WORDS);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
  localparam logic [WW-1:0] LAST_W = WW'(DUMP_WORDS - 1);
  localparam logic [TW-1:0] LAST_T = TW'(NUM_TILE - 1);

  eot_state_t        phase_q, phase_d;
  logic [TW-1:0]     tile_q, tile_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WW-1:0]     widx_q, widx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_w, last_t;

  assign last_w = (widx_q == LAST_W);
  assign last_t = (tile_q == LAST_T);

  always_comb begin
    phase_d = phase_q;
    tile_d  = tile_q;
    addr_d  = addr_q;
    widx_d  = widx_q;
    data_d  = data_q;
    unique case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d = RD_REQ;
          tile_d  = '0;
          addr_d  = DUMP_BASE;
          widx_d  = '0;
        end
      end
      RD_REQ: begin
        if (rd_gnt) phase_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_vld) begin
          data_d  = rd_data;
          phase_d = OUT;
        end
      end
      OUT: begin
        if (dump_rdy) begin
          if (last_w) begin
            widx_d = '0;
            addr_d = DUMP_BASE;
            // Tile index parks on the last tile once the dump ends.
            if (last_t) begin
              phase_d = DONE;
            end else begin
              tile_d  = tile_q + TW'(1);
              phase_d = RD_REQ;
            end
          end else begin
            widx_d  = widx_q + WW'(1);
            addr_d  = addr_q + STRIDE;
            phase_d = RD_REQ;
          end
        end
      end
      DONE: ;
      default: phase_d = IDLE;
    endcase
  end

  `LOTR_MSFF_RST(phase_q, phase_d, IDLE, clk, rst)
  `LOTR_MSFF_RST(tile_q, tile_d, '0, clk, rst)
  `LOTR_MSFF_RST(addr_q, addr_d, '0, clk, rst)
  `LOTR_MSFF_RST(widx_q, widx_d, '0, clk, rst)
  `LOTR_MSFF_RST(data_q, data_d, '0, clk, rst)

  assign rd_req    = (phase_q == RD_REQ);
  assign rd_tile   = tile_q;
  assign rd_addr   = addr_q;
  assign dump_vld  = (phase_q == OUT);
  assign dump_tile = tile_q;
  assign dump_addr = addr_q;
  assign dump_data = data_q;
  assign done      = (phase_q == DONE);

endmodule

// File: rtl/lotr_eot_ctrl.sv
// lotr_eot_ctrl: end-of-test controller; run FSM, cycle timeout, PASS/TIMEOUT status, d_mem dump.
// Ports: QClk/RstQnnnH, Enable, ThreadDone, Rd* read port, Dump* beat stream, Status, Eot, CycleCnt.
`ifndef LOTR_MSFF_RST
`define LOTR_MSFF_RST(q, d, rv, clk, rst) \
  always_ff @(posedge clk or posedge rst) \
    if (rst) q <= rv; \
    else q <= d;
`endif

module lotr_eot_ctrl
  import lotr_pkg::*;
#(
  parameter int                NUM_TILE    = 2,
  parameter int                NUM_THREAD  = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] DUMP_BASE   = '0,
  parameter int                DUMP_WORDS  = 256,
  parameter int                TIMEOUT_CYC = 20000
) (
  input  logic                               QClk,
  input  logic                               RstQnnnH,
  input  logic                               EnableQnnnH,
  input  logic [NUM_TILE*NUM_THREAD-1:0]     ThreadDoneQnnnH,
  output logic                               RdReqQnnnH,
  output logic [eot_tile_w(NUM_TILE)-1:0]    RdTileQnnnH,
  output logic [ADDR_W-1:0]                  RdAddrQnnnH,
  input  logic                               RdGntQnnnH,
  input  logic                               RdVldQnnnH,
  input  logic [DATA_W-1:0]                  RdDataQnnnH,
  output logic                               DumpVldQnnnH,
  input  logic                               DumpRdyQnnnH,
  output logic [eot_tile_w(NUM_TILE)-1:0]    DumpTileQnnnH,
  output logic [ADDR_W-1:0]                  DumpAddrQnnnH,
  output logic [DATA_W-1:0]                  DumpDataQnnnH,
  output logic [1:0]                         StatusQnnnH,
  output logic                               EotQnnnH,
  output logic [31:0]                        CycleCntQnnnH
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  // DONE here means the run phase is closed; the walker owns the dump.
  eot_state_t  state_q, state_d;
  eot_status_t status_q, status_d;
  logic [31:0] cnt_q, cnt_d;
  logic        start;
  logic        all_done;

  assign all_done = &ThreadDoneQnnnH;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EnableQnnnH) state_d = RUN;
      end
      RUN: begin
        // Done is tested first so it wins over a same-cycle timeout.
        if (EnableQnnnH) begin
          if (all_done) begin
            status_d = ST_PASS;
            state_d  = DONE;
            start    = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            status_d = ST_TIMEOUT;
            state_d  = DONE;
            start    = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  `LOTR_MSFF_RST(state_q, state_d, IDLE, QClk, RstQnnnH)
  `LOTR_MSFF_RST(status_q, status_d, ST_RUN, QClk, RstQnnnH)
  `LOTR_MSFF_RST(cnt_q, cnt_d, '0, QClk, RstQnnnH)

  assign StatusQnnnH   = status_q;
  assign CycleCntQnnnH = cnt_q;

  lotr_eot_walker #(
    .NUM_TILE   (NUM_TILE),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DUMP_BASE  (DUMP_BASE),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_walker (
    .clk       (QClk),
    .rst       (RstQnnnH),
    .start     (start),
    .rd_req    (RdReqQnnnH),
    .rd_tile   (RdTileQnnnH),
    .rd_addr   (RdAddrQnnnH),
    .rd_gnt    (RdGntQnnnH),
    .rd_vld    (RdVldQnnnH),
    .rd_data   (RdDataQnnnH),
    .dump_vld  (DumpVldQnnnH),
    .dump_rdy  (DumpRdyQnnnH),
    .dump_tile (DumpTileQnnnH),
    .dump_addr (DumpAddrQnnnH),
    .dump_data (DumpDataQnnnH),
    .done      (EotQnnnH)
  );

endmodule

// File: tb/tb_lotr_eot_ctrl.sv
// tb_lotr_eot_ctrl: randomized self-checking bench for lotr_eot_ctrl.
// Reference model tracks enabled cycles and builds the expected dump beat list.
module tb_lotr_eot_ctrl;

  localparam int NT   = 2;
  localparam int NTH  = 4;
  localparam int DW   = 4;
  localparam int T    = 100;
  localparam logic [31:0] BASE = 32'h100;
  localparam int NB   = NT * DW;

  typedef struct packed {
    logic        tile;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NT*NTH-1:0] tdone;
  logic              rd_req;
  logic              rd_tile;
  logic [31:0]       rd_addr;
  logic              rd_gnt;
  logic              rd_vld;
  logic [31:0]       rd_data;
  logic              d_vld;
  logic              d_rdy;
  logic              d_tile;
  logic [31:0]       d_addr;
  logic [31:0]       d_data;
  logic [1:0]        status;
  logic              eot;
  logic [31:0]       cyc_cnt;

  int          total;
  int          bad;
  logic [31:0] mem_seed;
  beat_t       exp_q[$];

  lotr_eot_ctrl #(
    .NUM_TILE    (NT),
    .NUM_THREAD  (NTH),
    .ADDR_W      (32),
    .DATA_W      (32),
    .DUMP_BASE   (BASE),
    .DUMP_WORDS  (DW),
    .TIMEOUT_CYC (T)
  ) dut (
    .QClk            (clk),
    .RstQnnnH        (rst),
    .EnableQnnnH     (en),
    .ThreadDoneQnnnH (tdone),
    .RdReqQnnnH      (rd_req),
    .RdTileQnnnH     (rd_tile),
    .RdAddrQnnnH     (rd_addr),
    .RdGntQnnnH      (rd_gnt),
    .RdVldQnnnH      (rd_vld),
    .RdDataQnnnH     (rd_data),
    .DumpVldQnnnH    (d_vld),
    .DumpRdyQnnnH    (d_rdy),
    .DumpTileQnnnH   (d_tile),
    .DumpAddrQnnnH   (d_addr),
    .DumpDataQnnnH   (d_data),
    .StatusQnnnH     (status),
    .EotQnnnH        (eot),
    .CycleCntQnnnH   (cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic t, input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {t, 31'h0} ^ mem_seed;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    tdone = '0;
    rd_gnt = 1'b0;
    rd_vld = 1'b0;
    rd_data = '0;
    d_rdy = 1'b0;
    mem_seed = $urandom;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({rd_req, d_vld, eot, status} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000", {rd_req, d_vld, eot, status});
    end
    total++;
    if (cyc_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", cyc_cnt);
    end
    total++;
    if ({rd_tile, rd_addr, d_tile, d_addr, d_data} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got %h/%h/%h want 0", rd_addr, d_addr, d_data);
    end
  endtask

  // Drives the run phase; model counts enabled RUN cycles and decides exit.
  task automatic do_run(input int done_at, input int off_s, input int off_n,
                        output logic [1:0] es, output logic [31:0] ec);
    int k;
    int cyc;
    int trk;
    bit ex;
    logic [31:0] mc;
    logic [7:0] v;
    k = 0;
    cyc = 0;
    trk = 0;
    ex = 0;
    es = 2'b00;
    ec = 0;
    while (!ex && cyc < 3000) begin
      @(negedge clk);
      mc = (k > 0) ? 32'(k - 1) : 32'd0;
      if (cyc_cnt !== mc || status !== 2'b00 || rd_req !== 1'b0) begin
        if (trk == 0)
          $display("FAIL run_track: cyc %0d got cnt=%0d st=%b want cnt=%0d st=00",
                   cyc, cyc_cnt, status, mc);
        trk++;
      end
      en = !(cyc >= off_s && cyc < off_s + off_n);
      v = 8'($urandom);
      v[3'($urandom_range(7, 0))] = 1'b0;
      if (done_at >= 0 && cyc >= done_at) v = '1;
      tdone = v;
      if (en) begin
        if (k == 0) k = 1;
        else if (&v) begin
          es = 2'b01;
          ec = 32'(k - 1);
          ex = 1;
        end else if (k - 1 == T - 1) begin
          es = 2'b10;
          ec = 32'(k - 1);
          ex = 1;
        end else k++;
      end
      cyc++;
    end
    total++;
    if (trk != 0 || !ex) begin
      bad++;
      $display("FAIL run_phase: got %0d errors want 0 (exit %0d)", trk, ex);
    end
    @(negedge clk);
    total++;
    if (status !== es) begin
      bad++;
      $display("FAIL status: got %b want %b", status, es);
    end
    total++;
    if (cyc_cnt !== ec) begin
      bad++;
      $display("FAIL exit_cnt: got %0d want %0d", cyc_cnt, ec);
    end
    total++;
    if (rd_req !== 1'b1) begin
      bad++;
      $display("FAIL first_req: got %b want 1", rd_req);
    end
  endtask

  // mode 0: all immediate; 1: gnt delay 3, beat 2 stalled 5; 2: random.
  task automatic run_dump(input int mode, input int abort_at,
                          input logic [1:0] es, input logic [31:0] ec);
    int beats;
    int c;
    int age;
    int vcnt;
    int stall;
    int serr;
    int eot_c;
    int gdly;
    bit pend;
    bit rw;
    bit ds;
    bit rdy;
    logic pt;
    logic [31:0] pa;
    logic ht;
    logic [31:0] hat;
    beat_t hb;
    beat_t ob;
    beat_t eb;
    beats = 0; c = 0; age = 0; vcnt = 0; stall = 0; serr = 0;
    eot_c = -1; pend = 0; rw = 0; ds = 0;
    pt = 0; pa = 0; ht = 0; hat = 0; hb = '0;
    gdly = (mode == 1) ? 3 : 0;
    exp_q.delete();
    for (int t = 0; t < NT; t++)
      for (int w = 0; w < DW; w++)
        exp_q.push_back('{tile: 1'(t), addr: BASE + 32'(4 * w),
                          data: mem_word(1'(t), BASE + 32'(4 * w))});
    while (c < 2000) begin
      if (abort_at >= 0 && d_vld && beats == abort_at) begin
        d_rdy = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({d_vld, rd_req, eot, status} !== 5'b0 || cyc_cnt !== 32'd0) begin
          bad++;
          $display("FAIL abort: got vld=%b req=%b eot=%b st=%b cnt=%0d want 0",
                   d_vld, rd_req, eot, status, cyc_cnt);
        end
        return;
      end
      if (pend) begin
        if (vcnt == 0) begin
          rd_vld = 1'b1;
          rd_data = mem_word(pt, pa);
          pend = 0;
        end else begin
          rd_vld = 1'b0;
          rd_data = $urandom;
          vcnt--;
        end
      end else begin
        rd_vld = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
        rd_data = $urandom;
      end
      rd_gnt = (mode == 0);
      if (rd_req) begin
        if (rw && (rd_tile !== ht || rd_addr !== hat)) serr++;
        if (age >= gdly) begin
          rd_gnt = 1'b1;
          pend = 1;
          pt = rd_tile;
          pa = rd_addr;
          age = 0;
          rw = 0;
          vcnt = (mode == 2) ? int'($urandom_range(3, 0)) : 0;
          if (mode == 2) gdly = int'($urandom_range(3, 0));
        end else begin
          rd_gnt = 1'b0;
          age++;
          rw = 1;
          ht = rd_tile;
          hat = rd_addr;
        end
      end else if (rw) serr++;
      ob = '{tile: d_tile, addr: d_addr, data: d_data};
      if (d_vld) begin
        if (ds && ob !== hb) serr++;
        if (mode == 0) rdy = 1;
        else if (mode == 1) rdy = !(beats == 2 && stall < 5);
        else rdy = ($urandom_range(9, 0) < 6);
        if (mode == 1 && !rdy) stall++;
        d_rdy = rdy;
        if (rdy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_extra: got %h want none", ob);
          end else begin
            eb = exp_q.pop_front();
            if (ob !== eb) begin
              bad++;
              $display("FAIL beat%0d: got %h want %h", beats, ob, eb);
            end
          end
          beats++;
          ds = 0;
        end else begin
          ds = 1;
          hb = ob;
        end
      end else begin
        if (ds) serr++;
        ds = 0;
        d_rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      end
      if (eot) begin
        eot_c = c;
        break;
      end
      tdone = NT*NTH'($urandom);
      en = 1'($urandom_range(1, 0));
      c++;
      @(negedge clk);
    end
    total++;
    if (eot_c < 0 || beats != NB) begin
      bad++;
      $display("FAIL dump_len: got beats=%0d eot_at=%0d want beats=%0d", beats, eot_c, NB);
    end
    total++;
    if (serr != 0) begin
      bad++;
      $display("FAIL handshake: got %0d violations want 0", serr);
    end
    if (mode == 0) begin
      total++;
      if (eot_c != 3 * NB) begin
        bad++;
        $display("FAIL latency: got %0d want %0d", eot_c, 3 * NB);
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (status !== es || cyc_cnt !== ec) begin
      bad++;
      $display("FAIL held: got st=%b cnt=%0d want st=%b cnt=%0d", status, cyc_cnt, es, ec);
    end
    total++;
    if ({eot, rd_req, d_vld} !== 3'b100) begin
      bad++;
      $display("FAIL eot_sticky: got %b want 100", {eot, rd_req, d_vld});
    end
  endtask

  task automatic test_pass_dump();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(50, -1, 0, es, ec);
    run_dump(0, -1, es, ec);
  endtask

  task automatic test_timeout();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(-1, -1, 0, es, ec);
    run_dump(2, -1, es, ec);
  endtask

  task automatic test_done_at_limit();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(T, -1, 0, es, ec);
    run_dump(0, -1, es, ec);
  endtask

  task automatic test_stall();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(20, -1, 0, es, ec);
    run_dump(1, -1, es, ec);
  endtask

  task automatic test_enable_hold();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(-1, 30, 20, es, ec);
    run_dump(0, -1, es, ec);
  endtask

  task automatic test_reset_mid();
    logic [1:0] es;
    logic [31:0] ec;
    apply_reset();
    do_run(10, -1, 0, es, ec);
    run_dump(0, 3, es, ec);
    apply_reset();
    do_run(15, -1, 0, es, ec);
    run_dump(2, -1, es, ec);
  endtask

  task automatic test_random();
    logic [1:0] es;
    logic [31:0] ec;
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      do_run(int'($urandom_range(140, 3)), int'($urandom_range(60, 1)),
             int'($urandom_range(15, 0)), es, ec);
      run_dump(2, -1, es, ec);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mem_seed = 0;
    en = 1'b0;
    tdone = '0;
    rd_gnt = 1'b0;
    rd_vld = 1'b0;
    rd_data = '0;
    d_rdy = 1'b0;
    rst = 1'b1;
    test_reset();
    test_pass_dump();
    test_timeout();
    test_done_at_limit();
    test_stall();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
